serv_arbiter: RTL and testbench
===============================

SERV_ARBITER -- requirements
Module: serv_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255, which sets the number of cycles a granted transfer may wait for i_wb_ack (used only when SERV_ARB_TIMEOUT_EN is defined).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-003 The block SHALL have port i_rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port i_ibus_adr, input, 32 bits: core instruction fetch address.
REQ-005 The block SHALL have port i_ibus_cyc, input, 1 bit: core instruction fetch request.
REQ-006 The block SHALL have port o_ibus_rdt, output, 32 bits: fetched instruction word.
REQ-007 The block SHALL have port o_ibus_ack, output, 1 bit: instruction fetch complete.
REQ-008 The block SHALL have ports i_dbus_adr (32 bits), i_dbus_dat (32 bits), i_dbus_sel (4 bits), i_dbus_we (1 bit) and i_dbus_cyc (1 bit), all inputs: core data request.
REQ-009 The block SHALL have ports o_dbus_rdt (32 bits) and o_dbus_ack (1 bit), both outputs: data read word and data transfer complete.
REQ-010 The block SHALL have ports o_wb_adr (32 bits), o_wb_dat (32 bits), o_wb_sel (4 bits), o_wb_we (1 bit) and o_wb_cyc (1 bit), all outputs: the shared Wishbone master port.
REQ-011 The block SHALL have ports i_wb_rdt (32 bits) and i_wb_ack (1 bit), both inputs: shared slave read data and acknowledge.
REQ-012 The block SHALL have port o_timeout, output, 1 bit: one-cycle pulse when a transfer is aborted; tied 0 when SERV_ARB_TIMEOUT_EN is undefined.

Function
REQ-013 The block SHALL implement a state machine with states IDLE, IBUS and DBUS.
REQ-014 In IDLE with i_dbus_cyc=1, the block SHALL enter DBUS on the next edge; dbus has priority when both requests are high in the same cycle.
REQ-015 In IDLE with i_ibus_cyc=1 and i_dbus_cyc=0, the block SHALL enter IBUS on the next edge.
REQ-016 On entering IBUS or DBUS, the block SHALL register the granted master's adr, dat, sel and we into o_wb_*; o_wb_cyc SHALL be 1 exactly while in IBUS or DBUS. Request-to-cyc latency is 1 cycle.
REQ-017 For an ibus transfer, the block SHALL force o_wb_we=0, o_wb_sel=4'b1111 and o_wb_dat=0.
REQ-018 In state S, o_<S>_ack SHALL equal i_wb_ack combinationally; the other master's ack SHALL be 0; both acks SHALL be 0 in IDLE.
REQ-019 o_ibus_rdt and o_dbus_rdt SHALL equal i_wb_rdt; they are meaningful only in the cycle their ack is high.
REQ-020 On i_wb_ack=1, the block SHALL return to IDLE on the next edge; this gives a minimum of 1 IDLE cycle between transfers.
REQ-021 If the granted master drops cyc before i_wb_ack, the block SHALL return to IDLE on the next edge and SHALL ignore a later stale i_wb_ack.
REQ-022 The registered o_wb_adr/dat/sel/we SHALL remain stable for the whole granted state, regardless of changes on the master inputs.

Reset
REQ-023 While i_rst=1 at an edge, the block SHALL set state=IDLE, o_wb_cyc=0, o_wb_we=0, o_wb_sel=0, o_wb_adr=0, o_wb_dat=0, o_timeout=0 and the timeout counter to 0.
REQ-024 Reset asserted mid-transfer SHALL abort the transfer without any ack to either master, with o_wb_cyc=0 in the cycle after the reset edge.

Configuration
REQ-025 With SERV_ARB_TIMEOUT_EN defined, the block SHALL count cycles spent in IBUS/DBUS (counter cleared in IDLE). When the count reaches TIMEOUT_CYCLES without ack, it SHALL, in that cycle: assert the granted master's ack with rdt forced to 0, pulse o_timeout, and go to IDLE on the next edge.
REQ-026 With SERV_ARB_TIMEOUT_EN defined, an i_wb_ack in the expiry cycle SHALL take precedence: normal ack, real rdt, o_timeout=0.
REQ-027 Without SERV_ARB_TIMEOUT_EN, the block SHALL have no counter, SHALL tie o_timeout to 0, and SHALL wait indefinitely for ack.

Verification
REQ-028 The bench SHALL drive i_ibus_cyc=1, adr=0x8 and ack on the 3rd cycle with rdt=0x00000013 -> o_wb_cyc=1 for 3 cycles, o_wb_adr=0x8, o_wb_we=0, o_ibus_ack pulses once with 0x13.
REQ-029 The bench SHALL raise i_ibus_cyc and i_dbus_cyc in the same cycle (dbus adr=0x100, we=1, sel=0xF, dat=0xDEADBEEF) -> DBUS granted first with o_wb_dat=0xDEADBEEF; IBUS granted after 1 IDLE cycle.
REQ-030 The bench SHALL change i_dbus_adr mid-transfer -> o_wb_adr holds the latched value until ack.
REQ-031 The bench SHALL assert i_rst during DBUS -> no ack to either master, o_wb_cyc=0 next cycle, state IDLE.
REQ-032 With SERV_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, the bench SHALL grant an ibus request and never ack -> o_ibus_ack=1 with rdt=0 and o_timeout pulse at the 4th cycle of IBUS; a second run with ack in that same cycle -> real rdt, o_timeout=0.

Source files
------------

// File: rtl/serv_arbiter.sv
// -----------------------------------------------------------------------------
// serv_arbiter
//   Shares one Wishbone master port between the SERV instruction bus (ibus)
//   and data bus (dbus). The data bus wins when both request in the same
//   cycle. The granted master's request is registered on grant, so the
//   Wishbone request is stable for the whole transfer and the request-to-cyc
//   latency is one cycle. After every transfer the arbiter spends at least
//   one cycle in IDLE.
//
//   Optional feature (macro SERV_ARB_TIMEOUT_EN): a transfer that gets no
//   i_wb_ack within TIMEOUT_CYCLES granted cycles is completed towards the
//   master with read data 0, and o_timeout pulses for that cycle. Without the
//   macro there is no counter, o_timeout is tied to 0 and the arbiter waits
//   for ack indefinitely.
//
// Parameters
//   TIMEOUT_CYCLES  granted cycles allowed before abort (must be >= 1;
//                   only used with SERV_ARB_TIMEOUT_EN)
//
// Ports
//   clk, i_rst                  clock (rising edge), sync active-high reset
//   i_ibus_adr/cyc              instruction fetch request
//   o_ibus_rdt/ack              instruction fetch response
//   i_dbus_adr/dat/sel/we/cyc   data request
//   o_dbus_rdt/ack              data response
//   o_wb_adr/dat/sel/we/cyc     shared Wishbone master request
//   i_wb_rdt/ack                shared Wishbone slave response
//   o_timeout                   one-cycle pulse when a transfer is aborted
// -----------------------------------------------------------------------------
module serv_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        i_rst,
   input  logic [31:0] i_ibus_adr,
   input  logic        i_ibus_cyc,
   output logic [31:0] o_ibus_rdt,
   output logic        o_ibus_ack,
   input  logic [31:0] i_dbus_adr,
   input  logic [31:0] i_dbus_dat,
   input  logic [3:0]  i_dbus_sel,
   input  logic        i_dbus_we,
   input  logic        i_dbus_cyc,
   output logic [31:0] o_dbus_rdt,
   output logic        o_dbus_ack,
   output logic [31:0] o_wb_adr,
   output logic [31:0] o_wb_dat,
   output logic [3:0]  o_wb_sel,
   output logic        o_wb_we,
   output logic        o_wb_cyc,
   input  logic [31:0] i_wb_rdt,
   input  logic        i_wb_ack,
   output logic        o_timeout
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      IBUS = 2'd1,
      DBUS = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] wb_adr_q, wb_adr_d;
   logic [31:0] wb_dat_q, wb_dat_d;
   logic [3:0]  wb_sel_q, wb_sel_d;
   logic        wb_we_q, wb_we_d;

   logic        granted;     // a master currently owns the bus
   logic        granted_cyc; // the owning master still holds its request
   logic        tmo_hit;     // transfer expires this cycle without a real ack
   logic        bus_ack;     // completion seen by the owning master

   assign granted     = (state_q != IDLE);
   assign granted_cyc = ((state_q == IBUS) && i_ibus_cyc) ||
                        ((state_q == DBUS) && i_dbus_cyc);

`ifdef SERV_ARB_TIMEOUT_EN
   // The counter holds the number of granted cycles already completed, so the
   // Nth granted cycle sees N-1 and expiry is the cycle where it equals
   // TIMEOUT_CYCLES-1.
   localparam int unsigned     CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

   always_comb begin
      tmo_cnt_d = '0;
      if (granted && (tmo_cnt_q != CNT_LAST)) begin
         tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (i_rst) begin
         tmo_cnt_q <= '0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
      end
   end

   // A real ack in the expiry cycle wins over the timeout.
   assign tmo_hit = granted_cyc && (tmo_cnt_q == CNT_LAST) && !i_wb_ack;
`else
   // Keeps the parameter referenced in the build without the timeout feature.
   localparam int unsigned UNUSED_TIMEOUT_CYCLES = TIMEOUT_CYCLES;

   assign tmo_hit = 1'b0;
`endif

   // Acks are suppressed while reset is asserted so a reset mid-transfer never
   // completes the aborted access towards either master.
   assign bus_ack    = (i_wb_ack || tmo_hit) && !i_rst;
   assign o_ibus_ack = (state_q == IBUS) && bus_ack;
   assign o_dbus_ack = (state_q == DBUS) && bus_ack;
   assign o_ibus_rdt = tmo_hit ? 32'h0 : i_wb_rdt;
   assign o_dbus_rdt = tmo_hit ? 32'h0 : i_wb_rdt;
   assign o_timeout  = tmo_hit && !i_rst;

   assign o_wb_cyc = granted;
   assign o_wb_adr = wb_adr_q;
   assign o_wb_dat = wb_dat_q;
   assign o_wb_sel = wb_sel_q;
   assign o_wb_we  = wb_we_q;

   always_comb begin
      state_d  = state_q;
      wb_adr_d = wb_adr_q;
      wb_dat_d = wb_dat_q;
      wb_sel_d = wb_sel_q;
      wb_we_d  = wb_we_q;
      case (state_q)
         IDLE: begin
            if (i_dbus_cyc) begin
               state_d  = DBUS;
               wb_adr_d = i_dbus_adr;
               wb_dat_d = i_dbus_dat;
               wb_sel_d = i_dbus_sel;
               wb_we_d  = i_dbus_we;
            end else if (i_ibus_cyc) begin
               // Instruction fetches are always full-word reads.
               state_d  = IBUS;
               wb_adr_d = i_ibus_adr;
               wb_dat_d = 32'h0;
               wb_sel_d = 4'b1111;
               wb_we_d  = 1'b0;
            end
         end
         IBUS: begin
            if (!i_ibus_cyc || i_wb_ack || tmo_hit) begin
               state_d = IDLE;
            end
         end
         DBUS: begin
            if (!i_dbus_cyc || i_wb_ack || tmo_hit) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (i_rst) begin
         state_q  <= IDLE;
         wb_adr_q <= 32'h0;
         wb_dat_q <= 32'h0;
         wb_sel_q <= 4'h0;
         wb_we_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         wb_adr_q <= wb_adr_d;
         wb_dat_q <= wb_dat_d;
         wb_sel_q <= wb_sel_d;
         wb_we_q  <= wb_we_d;
      end
   end

endmodule

// File: tb/tb_serv_arbiter.sv
// -----------------------------------------------------------------------------
// tb_serv_arbiter
//   Directed bench for serv_arbiter. The stimulus process drives requests and
//   slave responses, checks the Wishbone request side directly, and pushes the
//   expected master-side completion into a queue whenever it issues an ack
//   (or expects a timeout). A separate monitor pops and compares whenever
//   either master ack is presented.
// -----------------------------------------------------------------------------
module tb_serv_arbiter;

   logic        clk = 1'b0;
   logic        i_rst = 1'b1;
   logic [31:0] i_ibus_adr = '0;
   logic        i_ibus_cyc = 1'b0;
   logic [31:0] o_ibus_rdt;
   logic        o_ibus_ack;
   logic [31:0] i_dbus_adr = '0;
   logic [31:0] i_dbus_dat = '0;
   logic [3:0]  i_dbus_sel = '0;
   logic        i_dbus_we = 1'b0;
   logic        i_dbus_cyc = 1'b0;
   logic [31:0] o_dbus_rdt;
   logic        o_dbus_ack;
   logic [31:0] o_wb_adr;
   logic [31:0] o_wb_dat;
   logic [3:0]  o_wb_sel;
   logic        o_wb_we;
   logic        o_wb_cyc;
   logic [31:0] i_wb_rdt = '0;
   logic        i_wb_ack = 1'b0;
   logic        o_timeout;

   int errors = 0;
   int checks = 0;

   typedef struct {
      bit          is_d;
      logic [31:0] rdt;
      bit          tmo;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      bit          we;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   serv_arbiter #(.TIMEOUT_CYCLES(4)) dut (
      .clk        (clk),
      .i_rst      (i_rst),
      .i_ibus_adr (i_ibus_adr),
      .i_ibus_cyc (i_ibus_cyc),
      .o_ibus_rdt (o_ibus_rdt),
      .o_ibus_ack (o_ibus_ack),
      .i_dbus_adr (i_dbus_adr),
      .i_dbus_dat (i_dbus_dat),
      .i_dbus_sel (i_dbus_sel),
      .i_dbus_we  (i_dbus_we),
      .i_dbus_cyc (i_dbus_cyc),
      .o_dbus_rdt (o_dbus_rdt),
      .o_dbus_ack (o_dbus_ack),
      .o_wb_adr   (o_wb_adr),
      .o_wb_dat   (o_wb_dat),
      .o_wb_sel   (o_wb_sel),
      .o_wb_we    (o_wb_we),
      .o_wb_cyc   (o_wb_cyc),
      .i_wb_rdt   (i_wb_rdt),
      .i_wb_ack   (i_wb_ack),
      .o_timeout  (o_timeout)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push(input bit is_d, input logic [31:0] rdt, input bit tmo,
                       input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input bit we);
      exp_t e;
      e.is_d = is_d; e.rdt = rdt; e.tmo = tmo;
      e.adr = adr; e.dat = dat; e.sel = sel; e.we = we;
      exp_q.push_back(e);
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled on
   // the falling edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic chk_req(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input bit we);
      chk({tag, "_cyc"}, o_wb_cyc, 1);
      chk({tag, "_adr"}, o_wb_adr, adr);
      chk({tag, "_dat"}, o_wb_dat, dat);
      chk({tag, "_sel"}, o_wb_sel, sel);
      chk({tag, "_we"},  o_wb_we,  we);
   endtask

   // Monitor: every presented master ack is matched against the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (o_ibus_ack || o_dbus_ack) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_ack: got ibus_ack=%0b dbus_ack=%0b expected none",
                        o_ibus_ack, o_dbus_ack);
            end else begin
               e = exp_q.pop_front();
               chk("ack_which", {30'b0, o_ibus_ack, o_dbus_ack}, e.is_d ? 32'd1 : 32'd2);
               chk("ack_rdt", e.is_d ? o_dbus_rdt : o_ibus_rdt, e.rdt);
               chk("ack_timeout", o_timeout, e.tmo);
               chk("ack_wb_adr", o_wb_adr, e.adr);
               chk("ack_wb_dat", o_wb_dat, e.dat);
               chk("ack_wb_sel", o_wb_sel, e.sel);
               chk("ack_wb_we", o_wb_we, e.we);
            end
         end else if (o_timeout) begin
            checks++;
            errors++;
            $display("FAIL timeout_without_ack: got o_timeout=1 expected 0");
         end
      end
   end

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      smp();
      chk("rst_cyc", o_wb_cyc, 0);
      chk("rst_adr", o_wb_adr, 0);
      chk("rst_dat", o_wb_dat, 0);
      chk("rst_sel", o_wb_sel, 0);
      chk("rst_we", o_wb_we, 0);
      chk("rst_timeout", o_timeout, 0);
      chk("rst_acks", {o_ibus_ack, o_dbus_ack}, 0);

      // Single instruction fetch, ack on the 3rd granted cycle
      tick(); i_rst = 1'b0; i_ibus_cyc = 1'b1; i_ibus_adr = 32'h8;
      smp(); chk("a_latency_cyc", o_wb_cyc, 0);
      tick(); smp(); chk_req("a_c1", 32'h8, 32'h0, 4'hF, 1'b0);
      tick(); smp(); chk("a_c2_cyc", o_wb_cyc, 1);
      tick(); i_wb_ack = 1'b1; i_wb_rdt = 32'h0000_0013;
      push(1'b0, 32'h13, 1'b0, 32'h8, 32'h0, 4'hF, 1'b0);
      smp(); chk("a_c3_cyc", o_wb_cyc, 1);
      tick(); i_wb_ack = 1'b0; i_ibus_cyc = 1'b0;
      smp(); chk("a_idle_cyc", o_wb_cyc, 0);

      // Simultaneous requests: dbus first, stable request, then ibus
      tick();
      i_ibus_cyc = 1'b1; i_ibus_adr = 32'h40;
      i_dbus_cyc = 1'b1; i_dbus_adr = 32'h100; i_dbus_we = 1'b1;
      i_dbus_sel = 4'hF; i_dbus_dat = 32'hDEAD_BEEF;
      smp(); chk("b_latency_cyc", o_wb_cyc, 0);
      tick(); smp(); chk_req("b_dbus", 32'h100, 32'hDEAD_BEEF, 4'hF, 1'b1);
      tick(); i_dbus_adr = 32'h200; i_dbus_dat = 32'h1234_5678;
      smp(); chk("b_hold_adr", o_wb_adr, 32'h100); chk("b_hold_dat", o_wb_dat, 32'hDEAD_BEEF);
      tick(); i_wb_ack = 1'b1; i_wb_rdt = 32'hCAFE_F00D;
      push(1'b1, 32'hCAFE_F00D, 1'b0, 32'h100, 32'hDEAD_BEEF, 4'hF, 1'b1);
      smp();
      tick(); i_wb_ack = 1'b0; i_dbus_cyc = 1'b0; i_dbus_sel = 4'h3;
      smp(); chk("b_gap_cyc", o_wb_cyc, 0);
      tick(); smp(); chk_req("b_ibus", 32'h40, 32'h0, 4'hF, 1'b0);
      tick(); i_wb_ack = 1'b1; i_wb_rdt = 32'h0000_0093;
      push(1'b0, 32'h93, 1'b0, 32'h40, 32'h0, 4'hF, 1'b0);
      smp();
      tick(); i_wb_ack = 1'b0; i_ibus_cyc = 1'b0;
      smp(); chk("b_end_cyc", o_wb_cyc, 0);

      // Reset during a dbus transfer
      tick();
      i_dbus_cyc = 1'b1; i_dbus_adr = 32'h300; i_dbus_we = 1'b0;
      i_dbus_sel = 4'h3; i_dbus_dat = 32'h55;
      smp();
      tick(); smp(); chk_req("c_dbus", 32'h300, 32'h55, 4'h3, 1'b0);
      tick(); i_rst = 1'b1;
      smp(); chk("c_rst_acks", {o_ibus_ack, o_dbus_ack}, 0);
      tick(); i_rst = 1'b0; i_dbus_cyc = 1'b0; i_wb_ack = 1'b1;
      smp();
      chk("c_post_cyc", o_wb_cyc, 0);
      chk("c_post_adr", o_wb_adr, 0);
      chk("c_post_dat", o_wb_dat, 0);
      chk("c_post_sel", o_wb_sel, 0);
      chk("c_idle_acks", {o_ibus_ack, o_dbus_ack}, 0);
      tick(); i_wb_ack = 1'b0;

      // Master drops cyc before ack; later stale ack is ignored
      tick(); i_ibus_cyc = 1'b1; i_ibus_adr = 32'h80;
      smp();
      tick(); i_ibus_cyc = 1'b0;
      smp(); chk("d_cyc", o_wb_cyc, 1); chk("d_adr", o_wb_adr, 32'h80);
      chk("d_no_ack", o_ibus_ack, 0);
      tick(); i_wb_ack = 1'b1;
      smp(); chk("d_drop_cyc", o_wb_cyc, 0); chk("d_stale_ack", o_ibus_ack, 0);
      tick(); i_wb_ack = 1'b0;

      // Never-acked fetch: timeout at the 4th granted cycle, or indefinite wait
      i_wb_rdt = 32'hFFFF_FFFF;
      tick(); i_ibus_cyc = 1'b1; i_ibus_adr = 32'hC0;
      smp();
      tick(); smp(); chk("e_c1_cyc", o_wb_cyc, 1);
      tick(); smp();
      tick(); smp(); chk("e_c3_timeout", o_timeout, 0); chk("e_c3_ack", o_ibus_ack, 0);
`ifdef SERV_ARB_TIMEOUT_EN
      tick(); push(1'b0, 32'h0, 1'b1, 32'hC0, 32'h0, 4'hF, 1'b0);
      smp(); chk("e_c4_cyc", o_wb_cyc, 1);
      tick(); i_ibus_cyc = 1'b0;
      smp(); chk("e_after_cyc", o_wb_cyc, 0); chk("e_after_timeout", o_timeout, 0);

      // Ack lands in the expiry cycle: real completion, no timeout
      tick(); i_ibus_cyc = 1'b1; i_ibus_adr = 32'hC4;
      smp();
      repeat (3) begin
         tick(); smp();
      end
      tick(); i_wb_ack = 1'b1; i_wb_rdt = 32'h77;
      push(1'b0, 32'h77, 1'b0, 32'hC4, 32'h0, 4'hF, 1'b0);
      smp();
      tick(); i_wb_ack = 1'b0; i_ibus_cyc = 1'b0;
      smp(); chk("f_end_cyc", o_wb_cyc, 0);
`else
      repeat (3) begin
         tick(); smp();
         chk("e_wait_cyc", o_wb_cyc, 1);
         chk("e_wait_ack", o_ibus_ack, 0);
         chk("e_wait_timeout", o_timeout, 0);
      end
      tick(); i_wb_ack = 1'b1; i_wb_rdt = 32'h77;
      push(1'b0, 32'h77, 1'b0, 32'hC0, 32'h0, 4'hF, 1'b0);
      smp();
      tick(); i_wb_ack = 1'b0; i_ibus_cyc = 1'b0;
      smp(); chk("e_end_cyc", o_wb_cyc, 0);
`endif

      repeat (3) tick();
      chk("pending_expected", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
